// File: rtl/satd_block_loader_if.sv
// Row-beat input and block output bundle of the SATD block loader.
interface satd_block_loader_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SAMPLES    = 8,
  parameter int unsigned ITERATIONS = 7
);
  localparam int unsigned ROW_W = WIDTH * SAMPLES;
  localparam int unsigned BLK_W = ROW_W * (ITERATIONS + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_sof;
  logic [ROW_W-1:0] in_org;
  logic [ROW_W-1:0] in_cur;
  logic             blk_valid;
  logic             blk_ready;
  logic [BLK_W-1:0] blk_org;
  logic [BLK_W-1:0] blk_cur;
  logic             err_align;

  // Producer of row beats and consumer of blocks.
  modport master (
    output in_valid, in_sof, in_org, in_cur, blk_ready,
    input  in_ready, blk_valid, blk_org, blk_cur, err_align
  );

  // The loader itself.
  modport slave (
    input  in_valid, in_sof, in_org, in_cur, blk_ready,
    output in_ready, blk_valid, blk_org, blk_cur, err_align
  );
endinterface

// File: rtl/satd_block_loader.sv
// Double-buffered block assembler: gathers ITERATIONS+1 org/cur rows into one
// of two banks and holds each completed bank on the block bus until released.
module satd_block_loader #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SAMPLES    = 8,
  parameter int unsigned ITERATIONS = 7
) (
  input logic                clk,
  input logic                rst,
  satd_block_loader_if.slave bus
);
  localparam int unsigned ROW_W = WIDTH * SAMPLES;
  localparam int unsigned BLK_W = ROW_W * (ITERATIONS + 1);

  logic [1:0][BLK_W-1:0] org_bank;
  logic [1:0][BLK_W-1:0] cur_bank;
  logic                  wr_bank;
  logic                  rd_bank;
  logic [3:0]            wr_row;
  logic [1:0]            full;
  logic                  err_q;

  logic                  accept_c;
  logic                  release_c;
  logic [3:0]            row_c;
  logic                  last_c;
  logic [31:0]           base_c;
  logic [1:0]            full_c;

  // Handshake decode and target row of the current beat.
  always_comb begin
    accept_c  = bus.in_valid && !full[wr_bank];
    release_c = full[rd_bank] && bus.blk_ready;
    row_c     = bus.in_sof ? 4'd0 : wr_row;
    last_c    = (row_c == 4'(ITERATIONS));
    base_c    = 32'(row_c) * 32'(ROW_W);
  end

  // Bank occupancy: a release and a completing write never hit the same bank.
  always_comb begin
    full_c = full;
    if (release_c) full_c[rd_bank] = 1'b0;
    if (accept_c && last_c) full_c[wr_bank] = 1'b1;
  end

  // Row data capture into the write bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      org_bank <= '0;
      cur_bank <= '0;
    end else if (accept_c) begin
      org_bank[wr_bank][base_c +: ROW_W] <= bus.in_org;
      cur_bank[wr_bank][base_c +: ROW_W] <= bus.in_cur;
    end
  end

  // Bank pointers, row counter, occupancy and sticky alignment error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      full    <= '0;
      err_q   <= 1'b0;
    end else begin
      full <= full_c;
      if (release_c) rd_bank <= ~rd_bank;
      if (accept_c) begin
        wr_row <= last_c ? 4'd0 : row_c + 4'd1;
        if (last_c) wr_bank <= ~wr_bank;
        if (bus.in_sof && (wr_row != 4'd0)) err_q <= 1'b1;
      end
    end
  end

  // Outputs come straight from registered state; no path from blk_ready or in_valid.
  assign bus.in_ready  = !full[wr_bank];
  assign bus.blk_valid = full[rd_bank];
  assign bus.blk_org   = org_bank[rd_bank];
  assign bus.blk_cur   = cur_bank[rd_bank];
  assign bus.err_align = err_q;
endmodule

// File: tb/tb_satd_block_loader.sv
// Bench for satd_block_loader: queue-of-blocks model plus directed checks.
module tb_satd_block_loader;
  localparam int unsigned ROW_W = 64;
  localparam int unsigned BLK_W = 512;
  localparam int unsigned ROW_B = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  satd_block_loader_if #(.WIDTH(8), .SAMPLES(8), .ITERATIONS(7)) bus_a ();
  satd_block_loader_if #(.WIDTH(8), .SAMPLES(4), .ITERATIONS(0)) bus_b ();

  satd_block_loader #(.WIDTH(8), .SAMPLES(8), .ITERATIONS(7)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a));
  satd_block_loader #(.WIDTH(8), .SAMPLES(4), .ITERATIONS(0)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] rowpat(input logic [7:0] b);
    return {8{b}};
  endfunction

  // Behavioural model: completed blocks wait in a queue of at most two.
  logic [BLK_W-1:0] m_org_q[$];
  logic [BLK_W-1:0] m_cur_q[$];
  logic [BLK_W-1:0] m_org_p, m_cur_p;
  int               m_row;
  logic             m_err;
  bit               chk_en = 1'b0;
  bit               m_acc, m_rel;
  int               m_r;

  always @(posedge clk) begin
    if (rst) begin
      m_org_q.delete();
      m_cur_q.delete();
      m_org_p = '0;
      m_cur_p = '0;
      m_row   = 0;
      m_err   = 1'b0;
    end else begin
      m_acc = bus_a.in_valid && (m_org_q.size() < 2);
      m_rel = (m_org_q.size() > 0) && bus_a.blk_ready;
      if (m_rel) begin
        void'(m_org_q.pop_front());
        void'(m_cur_q.pop_front());
      end
      if (m_acc) begin
        m_r = bus_a.in_sof ? 0 : m_row;
        if (bus_a.in_sof && m_row != 0) m_err = 1'b1;
        m_org_p[m_r*ROW_W +: ROW_W] = bus_a.in_org;
        m_cur_p[m_r*ROW_W +: ROW_W] = bus_a.in_cur;
        if (m_r == 7) begin
          m_org_q.push_back(m_org_p);
          m_cur_q.push_back(m_cur_p);
          m_row = 0;
        end else begin
          m_row = m_r + 1;
        end
      end
    end
  end

  // Per-cycle comparison of DUT A against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", BLK_W'(bus_a.in_ready), BLK_W'(m_org_q.size() < 2));
      chk("blk_valid", BLK_W'(bus_a.blk_valid), BLK_W'(m_org_q.size() > 0));
      chk("err_align", BLK_W'(bus_a.err_align), BLK_W'(m_err));
      if (m_org_q.size() > 0) begin
        chk("blk_org", bus_a.blk_org, m_org_q[0]);
        chk("blk_cur", bus_a.blk_cur, m_cur_q[0]);
      end
    end
  end

  // Release and stall monitor for the streaming phase.
  bit             mon_en = 1'b0;
  int             rel_cnt = 0;
  int             low_cnt = 0;
  logic [ROW_W-1:0] rel_row0[$];
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus_a.blk_valid && bus_a.blk_ready) begin
        rel_cnt++;
        rel_row0.push_back(bus_a.blk_org[63:0]);
      end
      if (!bus_a.in_ready) low_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [ROW_W-1:0] o, input logic [ROW_W-1:0] c, input logic sof);
    bit rdy;
    int n;
    n = 0;
    bus_a.in_valid = 1'b1;
    bus_a.in_org   = o;
    bus_a.in_cur   = c;
    bus_a.in_sof   = sof;
    do begin
      @(negedge clk);
      rdy = bus_a.in_ready;
      step();
      n++;
    end while (!rdy && n < 64);
    checks++;
    if (!rdy) begin
      errors++;
      $display("FAIL send_timeout: in_ready low for %0d cycles, expected a free bank", n);
    end
    bus_a.in_valid = 1'b0;
    bus_a.in_sof   = 1'b0;
  endtask

  task automatic release_a();
    bus_a.blk_ready = 1'b1;
    step();
    bus_a.blk_ready = 1'b0;
  endtask

  logic [BLK_W-1:0] exp_org, exp_cur;
  logic [ROW_B-1:0] b_org, b_cur, b_prev_org, b_prev_cur;

  initial begin
    rst = 1'b1;
    bus_a.in_valid = 1'b0; bus_a.in_sof = 1'b0; bus_a.in_org = '0; bus_a.in_cur = '0;
    bus_a.blk_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_sof = 1'b0; bus_b.in_org = '0; bus_b.in_cur = '0;
    bus_b.blk_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", BLK_W'(bus_a.in_ready), BLK_W'(1));
    chk("rst_blk_valid", BLK_W'(bus_a.blk_valid), BLK_W'(0));
    chk("rst_err", BLK_W'(bus_a.err_align), BLK_W'(0));
    chk("rst_org", bus_a.blk_org, BLK_W'(0));
    chk("rst_cur", bus_a.blk_cur, BLK_W'(0));
    chk_en = 1'b1;
    step();

    // One block of 8 rows, held for the consumer
    for (int r = 0; r < 8; r++) begin
      send(rowpat(8'(r)), rowpat(8'(8'hF0 + r)), r == 0);
      exp_org[r*ROW_W +: ROW_W] = rowpat(8'(r));
      exp_cur[r*ROW_W +: ROW_W] = rowpat(8'(8'hF0 + r));
    end
    @(negedge clk);
    chk("t1_valid", BLK_W'(bus_a.blk_valid), BLK_W'(1));
    chk("t1_org_lo", BLK_W'(bus_a.blk_org[7:0]), BLK_W'(8'h00));
    chk("t1_org_hi", BLK_W'(bus_a.blk_org[511:504]), BLK_W'(8'h07));
    chk("t1_cur_hi", BLK_W'(bus_a.blk_cur[511:504]), BLK_W'(8'hF7));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t1_hold_org", bus_a.blk_org, exp_org);
      chk("t1_hold_cur", bus_a.blk_cur, exp_cur);
    end
    step();
    release_a();
    @(negedge clk);
    chk("t1_released", BLK_W'(bus_a.blk_valid), BLK_W'(0));
    step();

    // 24 beats with no consumer: both banks fill, then drain one at a time
    for (int i = 1; i <= 16; i++) send(rowpat(8'(8'h10 + i)), rowpat(8'(8'h80 + i)), 1'b0);
    @(negedge clk);
    chk("t2_ready_low", BLK_W'(bus_a.in_ready), BLK_W'(0));
    chk("t2_blk0_row0", BLK_W'(bus_a.blk_org[63:0]), BLK_W'(rowpat(8'h11)));
    step();
    release_a();
    @(negedge clk);
    chk("t2_valid_after_rel", BLK_W'(bus_a.blk_valid), BLK_W'(1));
    chk("t2_blk1_row0", BLK_W'(bus_a.blk_org[63:0]), BLK_W'(rowpat(8'h19)));
    chk("t2_ready_back", BLK_W'(bus_a.in_ready), BLK_W'(1));
    step();
    for (int i = 17; i <= 24; i++) send(rowpat(8'(8'h10 + i)), rowpat(8'(8'h80 + i)), 1'b0);
    release_a();
    @(negedge clk);
    chk("t2_blk2_row0", BLK_W'(bus_a.blk_org[63:0]), BLK_W'(rowpat(8'h21)));
    chk("t2_blk2_row7", BLK_W'(bus_a.blk_org[511:448]), BLK_W'(rowpat(8'h28)));
    chk("t2_blk2_cur7", BLK_W'(bus_a.blk_cur[511:448]), BLK_W'(rowpat(8'h98)));
    step();
    release_a();

    // Continuous streaming with the consumer always ready
    bus_a.blk_ready = 1'b1;
    mon_en = 1'b1;
    for (int i = 1; i <= 32; i++) send(rowpat(8'(8'h40 + i)), rowpat(8'(8'hC0 + i)), i % 8 == 1);
    repeat (4) step();
    mon_en = 1'b0;
    bus_a.blk_ready = 1'b0;
    chk("t3_releases", BLK_W'(rel_cnt), BLK_W'(4));
    chk("t3_ready_low_cycles", BLK_W'(low_cnt), BLK_W'(0));
    for (int b = 0; b < 4; b++) begin
      if (b < rel_row0.size()) chk("t3_row0", BLK_W'(rel_row0[b]), BLK_W'(rowpat(8'(8'h41 + 8 * b))));
      else chk("t3_row0_missing", BLK_W'(b), BLK_W'(rel_row0.size()));
    end

    // Misaligned start of frame
    for (int i = 1; i <= 3; i++) send(rowpat(8'(8'h60 + i)), rowpat(8'(8'h60 + i)), i == 1);
    send(rowpat(8'hAA), rowpat(8'h55), 1'b1);
    exp_org[63:0] = rowpat(8'hAA);
    for (int i = 1; i <= 7; i++) begin
      send(rowpat(8'(8'h70 + i)), rowpat(8'(8'h70 + i)), 1'b0);
      exp_org[i*ROW_W +: ROW_W] = rowpat(8'(8'h70 + i));
    end
    @(negedge clk);
    chk("t4_err", BLK_W'(bus_a.err_align), BLK_W'(1));
    chk("t4_valid", BLK_W'(bus_a.blk_valid), BLK_W'(1));
    chk("t4_block", bus_a.blk_org, exp_org);
    step();
    release_a();

    // Reset while block 0 held and block 1 partly filled
    for (int i = 0; i < 13; i++) send(rowpat(8'(8'h90 + i)), rowpat(8'(8'h90 + i)), 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_valid", BLK_W'(bus_a.blk_valid), BLK_W'(0));
    chk("t5_ready", BLK_W'(bus_a.in_ready), BLK_W'(1));
    chk("t5_err", BLK_W'(bus_a.err_align), BLK_W'(0));
    chk("t5_org", bus_a.blk_org, BLK_W'(0));
    chk("t5_cur", bus_a.blk_cur, BLK_W'(0));
    step();
    for (int r = 0; r < 8; r++) begin
      send(rowpat(8'(8'hB0 + r)), rowpat(8'(8'hD0 + r)), 1'b0);
      exp_org[r*ROW_W +: ROW_W] = rowpat(8'(8'hB0 + r));
      exp_cur[r*ROW_W +: ROW_W] = rowpat(8'(8'hD0 + r));
    end
    @(negedge clk);
    chk("t5_new_valid", BLK_W'(bus_a.blk_valid), BLK_W'(1));
    chk("t5_new_org", bus_a.blk_org, exp_org);
    chk("t5_new_cur", bus_a.blk_cur, exp_cur);
    step();
    release_a();
    @(negedge clk);
    chk("t5_drained", BLK_W'(bus_a.blk_valid), BLK_W'(0));
    step();

    // Single-row blocks on the narrow instance
    chk("t6_idle_valid", BLK_W'(bus_b.blk_valid), BLK_W'(0));
    bus_b.blk_ready = 1'b1;
    b_prev_org = '0;
    b_prev_cur = '0;
    for (int i = 0; i < 6; i++) begin
      b_org = {4{8'(8'hC0 + i)}};
      b_cur = {4{8'(8'h30 + 3 * i)}};
      bus_b.in_valid = 1'b1;
      bus_b.in_org = b_org;
      bus_b.in_cur = b_cur;
      bus_b.in_sof = (i % 2 == 0);
      @(negedge clk);
      chk("t6_ready", BLK_W'(bus_b.in_ready), BLK_W'(1));
      if (i > 0) begin
        chk("t6_valid", BLK_W'(bus_b.blk_valid), BLK_W'(1));
        chk("t6_org", BLK_W'(bus_b.blk_org), BLK_W'(b_prev_org));
        chk("t6_cur", BLK_W'(bus_b.blk_cur), BLK_W'(b_prev_cur));
      end
      b_prev_org = b_org;
      b_prev_cur = b_cur;
      step();
    end
    bus_b.in_valid = 1'b0;
    @(negedge clk);
    chk("t6_last_valid", BLK_W'(bus_b.blk_valid), BLK_W'(1));
    chk("t6_last_org", BLK_W'(bus_b.blk_org), BLK_W'(32'hC5C5C5C5));
    step();
    @(negedge clk);
    chk("t6_drained", BLK_W'(bus_b.blk_valid), BLK_W'(0));
    chk("t6_err", BLK_W'(bus_b.err_align), BLK_W'(0));
    bus_b.blk_ready = 1'b0;

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end
endmodule

// File: doc/satd_block_loader.md
# satd_block_loader

Double-buffered block assembler on the write side of the SATD datapath. Accepts ORG/CUR pixel rows one at a time (SAMPLES pixels of WIDTH bits each) over a valid/ready handshake. Collects ITERATIONS+1 rows into a full block, then presents that block on the flat ORG/CUR buses the SATD core consumes. Two banks let the next block fill while the current one is held for the consumer.

## Interface
- WIDTH, 8, bits per pixel
- SAMPLES, 8, pixels per row beat
- ITERATIONS, 7, rows per block minus one (rows = ITERATIONS+1); legal range 0..15

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  row beat valid
- in_ready  out  1  loader can accept a beat this cycle
- in_sof  in  1  beat is row 0 of a new block
- in_org  in  WIDTH*SAMPLES  original row; pixel k at [k*WIDTH +: WIDTH]
- in_cur  in  WIDTH*SAMPLES  candidate row, same packing
- blk_valid  out  1  complete block presented on blk_org/blk_cur
- blk_ready  in  1  consumer releases the presented block
- blk_org  out  WIDTH*SAMPLES*(ITERATIONS+1)  row r at [r*SAMPLES*WIDTH +: SAMPLES*WIDTH]
- blk_cur  out  WIDTH*SAMPLES*(ITERATIONS+1)  same packing
- err_align  out  1  sticky flag: an in_sof beat arrived while a block was partly filled

## Operation
- State registers:
  - wr_bank (1 bit) and rd_bank (1 bit)
  - wr_row (4 bits)
  - full[1:0], one bit per bank
  - err_align
  - two banks of org/cur data registers
- in_ready = !full[wr_bank]. It depends only on registered state; there is no combinational path from blk_ready or in_valid.
- Beat accept = in_valid && in_ready. On accept, the beat is written to bank wr_bank at row index r:
  - r = 0 if in_sof, else r = wr_row.
  - If in_sof && wr_row != 0, set err_align. The partial rows stay in the bank and are overwritten as the new block fills.
  - If r == ITERATIONS: set full[wr_bank], toggle wr_bank, set wr_row to 0.
  - Otherwise set wr_row to r+1.
- in_sof with wr_row == 0 is legal and silent. in_sof is not required; absent in_sof, rows are counted implicitly.
- ITERATIONS == 0: every accepted beat completes a block.
- blk_valid = full[rd_bank]. blk_org/blk_cur are driven from bank rd_bank. They are stable while blk_valid is high and blk_ready is low.
- Release = blk_valid && blk_ready: clear full[rd_bank] and toggle rd_bank.
- blk_ready while blk_valid is low has no effect.
- A beat that completes bank A and a release of bank B in the same cycle are both applied.
- Write and release cannot target the same bank in the same cycle, because a full bank is never written.
- Rows of a block appear in arrival order. Each pixel is passed through unchanged; there is no arithmetic.

## Timing
- Reset values:
  - in_ready = 1, blk_valid = 0, err_align = 0
  - blk_org and blk_cur = 0 (all data registers cleared)
  - wr_bank = rd_bank = 0, wr_row = 0, full = 00
- Latency: blk_valid rises in the cycle after the last row beat is accepted.
- Throughput: 1 beat per cycle while a bank is free. Blocks stream back-to-back if blk_ready is held high.
- Both banks full: in_ready = 0. A release in cycle t raises in_ready in cycle t+1 (one-cycle bubble; this is intentional).
- err_align clears only on rst.
- rst asserted mid-block or mid-hold returns every register to its reset value in the next cycle. Partial and held blocks are discarded, and no blk_valid is produced for them.

## Test plan
- Reset, then 8 beats with ORG row r = all bytes r, CUR row r = all bytes 8'hF0+r, blk_ready = 0:
  - blk_valid = 1 in the cycle after beat 8.
  - blk_org[7:0] = 8'h00, blk_org[511:504] = 8'h07, blk_cur[511:504] = 8'hF7.
  - Outputs are held stable for 10 cycles.
- Stream 24 beats with blk_ready = 0:
  - in_ready drops after beat 16.
  - Pulse blk_ready: the block 0 data is released, blk_valid stays 1 and now shows block 1, in_ready returns 1 cycle later.
  - Beats 17-24 form block 2.
- Continuous 32 beats with blk_ready = 1:
  - 4 blk_valid/release pulses, in_ready never low.
  - Each block's row 0 equals beats 1, 9, 17, 25.
- 3 beats, then an in_sof beat with pattern 8'hAA, then 7 more beats:
  - err_align = 1.
  - The block presented has row 0 = 8'hAA and rows 1-7 = the following 7 beats.
- rst asserted after 5 beats of block 1 while block 0 is held:
  - Next cycle: blk_valid = 0, in_ready = 1, outputs 0.
  - 8 fresh beats yield one correct block.
- ITERATIONS = 0, SAMPLES = 4: each accepted beat raises blk_valid the next cycle with blk_org = that beat.
